add_pipe_n: RTL and testbench

Parametrised, pipelined N-bit adder/subtractor for the Vedic multiplier datapath. It generalises the fixed 6-bit ripple adder to any width and adds a carry input, a subtract mode, and signed overflow. The carry chain is split into SEG-bit segments with one register stage per segment, and a valid/ready handshake controls the pipeline. It is the partial-product summation adder for the 16x16 and wider Vedic multipliers, where a full-width ripple chain misses timing.

---
 rtl/vedic_pkg.sv | 33 +++
 rtl/add_seg_stage.sv | 39 +++
 rtl/add_pipe_n.sv | 127 ++++++++++++
 tb/tb_add_pipe_n.sv | 308 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/vedic_pkg.sv
`default_nettype none
// ============================================================================
// Module      : vedic_pkg
// Description : Shared helpers for the Vedic multiplier datapath: integer
//               ceiling division for sizing pipelines, and the half/full
//               adder cells used by the multiplier tree and the segmented
//               summation adder.
// Ports       : (package, no ports)
// Revision    : 1.0 - initial release
// ============================================================================
package vedic_pkg;

    // Ceiling of x / y for positive operands.
    function automatic int ceil_div(input int x, input int y);
        return (x + y - 1) / y;
    endfunction

    // Half adder cell: returns {carry, sum}.
    function automatic logic [1:0] half_adder(input logic x, input logic y);
        return {x & y, x ^ y};
    endfunction

    // Full adder cell built from two half adders: returns {carry, sum}.
    function automatic logic [1:0] full_adder(input logic x, input logic y, input logic ci);
        logic [1:0] h1;
        logic [1:0] h2;
        h1 = half_adder(x, y);
        h2 = half_adder(h1[0], ci);
        return {h1[1] | h2[1], h2[0]};
    endfunction

endpackage
`default_nettype wire

// File: rtl/add_seg_stage.sv
`default_nettype none
// ============================================================================
// Module      : add_seg_stage
// Description : SEG_W-bit ripple-carry segment made of full_adder cells.
//               Pure combinational; one instance per pipeline stage.
// Ports       : a, b   - segment operands (b already conditioned for sub)
//               cin    - carry into bit 0 of the segment
//               sum    - segment sum bits
//               cout   - carry out of the segment MSB
//               c_msb  - carry into the segment MSB (signed overflow source)
// Revision    : 1.0 - initial release
// ============================================================================
module add_seg_stage
    import vedic_pkg::*;
#(
    parameter int SEG_W = 4
) (
    input  logic [SEG_W-1:0] a,
    input  logic [SEG_W-1:0] b,
    input  logic             cin,
    output logic [SEG_W-1:0] sum,
    output logic             cout,
    output logic             c_msb
);

    // w_c[i] is the carry into bit i; w_c[SEG_W] leaves the segment.
    logic [SEG_W:0] w_c;

    assign w_c[0] = cin;

    for (genvar i = 0; i < SEG_W; i++) begin : g_bit
        assign {w_c[i+1], sum[i]} = full_adder(a[i], b[i], w_c[i]);
    end

    assign cout  = w_c[SEG_W];
    assign c_msb = w_c[SEG_W-1];

endmodule
`default_nettype wire

// File: rtl/add_pipe_n.sv
`default_nettype none
// ============================================================================
// Module      : add_pipe_n
// Description : Pipelined WIDTH-bit adder/subtractor. The carry chain is cut
//               into SEG-bit segments, one register stage per segment, with
//               a valid/ready handshake and a single global stall.
// Ports       : clk, rst_n          - clock, async active-low reset
//               in_valid / in_ready - operand handshake
//               a, b, cin, sub      - operands, carry in, subtract select
//               out_valid/out_ready - result handshake
//               sum, cout, ovf      - result, carry out, signed overflow
// Revision    : 1.0 - initial release
// ============================================================================
module add_pipe_n
    import vedic_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int SEG   = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);

    localparam int STAGES = ceil_div(WIDTH, SEG);

    // Stage registers. r_s holds the sum bits resolved so far (upper bits
    // stay zero); r_a/r_b carry the operands forward so later stages can
    // pick up their segment. r_b is already conditioned by sub.
    logic             r_v [STAGES];
    logic             r_c [STAGES];
    logic [WIDTH-1:0] r_s [STAGES];
    logic [WIDTH-1:0] r_a [STAGES];
    logic [WIDTH-1:0] r_b [STAGES];
    logic             r_ovf;

    // Per-stage inputs and next-state values.
    logic             w_v_in [STAGES];
    logic             w_c_in [STAGES];
    logic [WIDTH-1:0] w_s_in [STAGES];
    logic [WIDTH-1:0] w_a_in [STAGES];
    logic [WIDTH-1:0] w_b_in [STAGES];
    logic [WIDTH-1:0] w_s_nx [STAGES];
    logic             w_cout [STAGES];
    logic             w_cmsb [STAGES];

    logic             w_enable;

    // Whole pipeline advances together; only a held result blocks it.
    assign w_enable = !r_v[STAGES-1] || out_ready;

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        localparam int LO = k * SEG;
        localparam int SW = (k == STAGES - 1) ? (WIDTH - LO) : SEG;

        logic [SW-1:0] w_seg_sum;

        if (k == 0) begin : g_first
            // Subtract as a + ~b + 1; cin only matters when adding.
            assign w_v_in[k] = in_valid;
            assign w_a_in[k] = a;
            assign w_b_in[k] = b ^ {WIDTH{sub}};
            assign w_c_in[k] = sub | cin;
            assign w_s_in[k] = '0;
        end else begin : g_next
            assign w_v_in[k] = r_v[k-1];
            assign w_a_in[k] = r_a[k-1];
            assign w_b_in[k] = r_b[k-1];
            assign w_c_in[k] = r_c[k-1];
            assign w_s_in[k] = r_s[k-1];
        end

        add_seg_stage #(
            .SEG_W (SW)
        ) u_seg (
            .a     (w_a_in[k][LO +: SW]),
            .b     (w_b_in[k][LO +: SW]),
            .cin   (w_c_in[k]),
            .sum   (w_seg_sum),
            .cout  (w_cout[k]),
            .c_msb (w_cmsb[k])
        );

        // Bits of this segment are still zero in w_s_in, so OR merges them.
        assign w_s_nx[k] = w_s_in[k] | (WIDTH'(w_seg_sum) << LO);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < STAGES; k++) begin
                r_v[k] <= 1'b0;
                r_c[k] <= 1'b0;
                r_s[k] <= '0;
                r_a[k] <= '0;
                r_b[k] <= '0;
            end
            r_ovf <= 1'b0;
        end else if (w_enable) begin
            for (int k = 0; k < STAGES; k++) begin
                r_v[k] <= w_v_in[k];
                r_c[k] <= w_cout[k];
                r_s[k] <= w_s_nx[k];
                r_a[k] <= w_a_in[k];
                r_b[k] <= w_b_in[k];
            end
            r_ovf <= w_cmsb[STAGES-1] ^ w_cout[STAGES-1];
        end
    end

    assign in_ready  = w_enable;
    assign out_valid = r_v[STAGES-1];
    assign sum       = r_s[STAGES-1];
    assign cout      = r_c[STAGES-1];
    assign ovf       = r_ovf;

endmodule
`default_nettype wire

// File: tb/tb_add_pipe_n.sv
`default_nettype none
// ============================================================================
// Module      : tb_add_pipe_n
// Description : Self-checking bench for add_pipe_n. Two instances
//               (16/4 and 6/4) checked against an arithmetic reference
//               model through a scoreboard queue, plus directed cases.
// Ports       : (none)
// Revision    : 1.0 - initial release
// ============================================================================
module tb_add_pipe_n;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    always #5 clk = ~clk;

    logic        in_valid16, in_ready16, cin16, sub16;
    logic        out_valid16, out_ready16, cout16, ovf16;
    logic [15:0] a16, b16, sum16;

    logic        in_valid6, in_ready6, cin6, sub6;
    logic        out_valid6, out_ready6, cout6, ovf6;
    logic [5:0]  a6, b6, sum6;

    add_pipe_n #(.WIDTH(16), .SEG(4)) dut16 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid16), .in_ready(in_ready16),
        .a(a16), .b(b16), .cin(cin16), .sub(sub16),
        .out_valid(out_valid16), .out_ready(out_ready16),
        .sum(sum16), .cout(cout16), .ovf(ovf16)
    );

    add_pipe_n #(.WIDTH(6), .SEG(4)) dut6 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid6), .in_ready(in_ready6),
        .a(a6), .b(b6), .cin(cin6), .sub(sub6),
        .out_valid(out_valid6), .out_ready(out_ready6),
        .sum(sum6), .cout(cout6), .ovf(ovf6)
    );

    int n_vec = 0;
    int n_err = 0;

    logic [17:0] q16 [$];
    logic [17:0] q6  [$];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Reference: plain integer arithmetic on unsigned and signed views.
    function automatic logic [17:0] ref_model(input int w, input longint av, input longint bv,
                                              input bit c, input bit s);
        longint m;
        longint half;
        longint sa;
        longint sb;
        longint r;
        longint sr;
        bit     co;
        bit     ov;
        m    = longint'(1) << w;
        half = m / 2;
        sa   = (av >= half) ? av - m : av;
        sb   = (bv >= half) ? bv - m : bv;
        if (s) begin
            r  = av - bv;
            co = (av >= bv);
            sr = sa - sb;
        end else begin
            r  = av + bv + longint'(c);
            co = (r >= m);
            sr = sa + sb + longint'(c);
        end
        ov = (sr < -half) || (sr >= half);
        r  = ((r % m) + m) % m;
        return {16'(r), co, ov};
    endfunction

    // Scoreboard: predict on acceptance, compare on consumption.
    always @(negedge clk) begin
        if (rst_n) begin
            if (in_valid16 && in_ready16)
                q16.push_back(ref_model(16, longint'(a16), longint'(b16), cin16, sub16));
            if (out_valid16 && out_ready16) begin
                if (q16.size() == 0) chk("spurious16", 32'(out_valid16), 0);
                else chk("beat16", 32'({sum16, cout16, ovf16}), 32'(q16.pop_front()));
            end
            if (in_valid6 && in_ready6)
                q6.push_back(ref_model(6, longint'(a6), longint'(b6), cin6, sub6));
            if (out_valid6 && out_ready6) begin
                if (q6.size() == 0) chk("spurious6", 32'(out_valid6), 0);
                else chk("beat6", 32'({10'b0, sum6, cout6, ovf6}), 32'(q6.pop_front()));
            end
        end
    end

    task automatic dir16(input string tag, input logic [15:0] ta, input logic [15:0] tb,
                         input logic tc, input logic ts, input logic [17:0] exp);
        int lat;
        a16 = ta; b16 = tb; cin16 = tc; sub16 = ts;
        in_valid16 = 1'b1; out_ready16 = 1'b1;
        @(posedge clk); #1;
        in_valid16 = 1'b0;
        lat = 1;
        while (!out_valid16 && lat < 50) begin
            @(posedge clk); #1;
            lat++;
        end
        chk({tag, "_lat"}, 32'(lat), 4);
        chk(tag, 32'({sum16, cout16, ovf16}), 32'(exp));
        @(posedge clk); #1;
    endtask

    task automatic dir6(input string tag, input logic [5:0] ta, input logic [5:0] tb,
                        input logic tc, input logic ts, input logic [7:0] exp);
        int lat;
        a6 = ta; b6 = tb; cin6 = tc; sub6 = ts;
        in_valid6 = 1'b1; out_ready6 = 1'b1;
        @(posedge clk); #1;
        in_valid6 = 1'b0;
        lat = 1;
        while (!out_valid6 && lat < 50) begin
            @(posedge clk); #1;
            lat++;
        end
        chk({tag, "_lat"}, 32'(lat), 2);
        chk(tag, 32'({sum6, cout6, ovf6}), 32'(exp));
        @(posedge clk); #1;
    endtask

    task automatic stall16();
        logic [17:0] snap;
        out_ready16 = 1'b1;
        fork
            begin
                for (int i = 0; i < 8; i++) begin
                    logic acc;
                    int   g;
                    a16 = 16'(i); b16 = 16'(i * 256); cin16 = 1'b0; sub16 = 1'b0;
                    in_valid16 = 1'b1;
                    g = 0;
                    do begin
                        @(negedge clk); acc = in_ready16;
                        @(posedge clk); #1; g++;
                    end while (!acc && g < 50);
                end
                in_valid16 = 1'b0;
            end
            begin
                int g;
                g = 0;
                while (!out_valid16 && g < 50) begin
                    @(posedge clk); #1; g++;
                end
                out_ready16 = 1'b0;
                snap = {sum16, cout16, ovf16};
                for (int s = 0; s < 3; s++) begin
                    @(negedge clk);
                    chk("stall_ready", 32'(in_ready16), 0);
                    chk("stall_valid", 32'(out_valid16), 1);
                    chk("stall_hold", 32'({sum16, cout16, ovf16}), 32'(snap));
                    @(posedge clk); #1;
                end
                out_ready16 = 1'b1;
                for (int i = 0; i < 8; i++) begin
                    @(negedge clk);
                    chk("nogap", 32'(out_valid16), 1);
                    chk("stall_sum", 32'(sum16), i * 257);
                    @(posedge clk); #1;
                end
            end
        join
    endtask

    task automatic rand16(input int nbeats);
        int   sent;
        int   guard;
        logic acc;
        sent = 0; guard = 0; acc = 1'b0;
        in_valid16 = 1'b0;
        while (sent < nbeats && guard < 20000) begin
            out_ready16 = ($urandom_range(0, 3) != 0);
            if (!in_valid16 || acc) begin
                in_valid16 = ($urandom_range(0, 4) != 0);
                a16   = 16'($urandom);
                b16   = 16'($urandom);
                cin16 = 1'($urandom_range(0, 1));
                sub16 = 1'($urandom_range(0, 1));
            end
            @(negedge clk);
            acc = in_valid16 && in_ready16;
            if (acc) sent++;
            @(posedge clk); #1;
            guard++;
        end
        in_valid16 = 1'b0;
        out_ready16 = 1'b1;
        chk("sent16", 32'(sent), 32'(nbeats));
        guard = 0;
        while (q16.size() != 0 && guard < 100) begin
            @(posedge clk); #1; guard++;
        end
        chk("drain16", 32'(q16.size()), 0);
    endtask

    task automatic exhaust6();
        int g;
        logic acc;
        out_ready6 = 1'b1;
        for (int ai = 0; ai < 64; ai++)
            for (int bi = 0; bi < 64; bi++)
                for (int ci = 0; ci < 2; ci++)
                    for (int si = 0; si < 2; si++) begin
                        a6 = 6'(ai); b6 = 6'(bi); cin6 = 1'(ci); sub6 = 1'(si);
                        in_valid6 = 1'b1;
                        g = 0;
                        do begin
                            @(negedge clk); acc = in_ready6;
                            @(posedge clk); #1; g++;
                        end while (!acc && g < 50);
                    end
        in_valid6 = 1'b0;
        g = 0;
        while (q6.size() != 0 && g < 100) begin
            @(posedge clk); #1; g++;
        end
        chk("drain6", 32'(q6.size()), 0);
    endtask

    task automatic reset_mid16();
        int g;
        logic acc;
        out_ready16 = 1'b0;
        for (int i = 0; i < 3; i++) begin
            a16 = 16'(100 + i); b16 = 16'(7); cin16 = 1'b0; sub16 = 1'b0;
            in_valid16 = 1'b1;
            g = 0;
            do begin
                @(negedge clk); acc = in_ready16;
                @(posedge clk); #1; g++;
            end while (!acc && g < 50);
        end
        in_valid16 = 1'b0;
        g = 0;
        while (!out_valid16 && g < 50) begin
            @(posedge clk); #1; g++;
        end
        chk("pre_rst_valid", 32'(out_valid16), 1);
        @(negedge clk); #2;
        rst_n = 1'b0;
        #1;
        chk("rst_async_valid", 32'(out_valid16), 0);
        chk("rst_async_sum", 32'({sum16, cout16, ovf16}), 0);
        chk("rst_async_ready", 32'(in_ready16), 1);
        q16.delete();
        @(posedge clk); @(posedge clk); #1;
        rst_n = 1'b1;
        out_ready16 = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            chk("post_rst_idle", 32'(out_valid16), 0);
            @(posedge clk); #1;
        end
    endtask

    initial begin
        in_valid16 = 1'b0; a16 = '0; b16 = '0; cin16 = 1'b0; sub16 = 1'b0; out_ready16 = 1'b1;
        in_valid6  = 1'b0; a6  = '0; b6  = '0; cin6  = 1'b0; sub6  = 1'b0; out_ready6  = 1'b1;
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_valid16", 32'(out_valid16), 0);
        chk("rst_out16", 32'({sum16, cout16, ovf16}), 0);
        chk("rst_ready16", 32'(in_ready16), 1);
        chk("rst_valid6", 32'(out_valid6), 0);
        chk("rst_out6", 32'({sum6, cout6, ovf6}), 0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        dir16("add_wrap",  16'hFFFF, 16'h0001, 1'b0, 1'b0, {16'h0000, 1'b1, 1'b0});
        dir16("add_ovf",   16'h7FFF, 16'h0001, 1'b1, 1'b0, {16'h8001, 1'b0, 1'b1});
        dir16("sub_borrow",16'h0003, 16'h0005, 1'b1, 1'b1, {16'hFFFE, 1'b0, 1'b0});
        dir16("sub_ovf",   16'h8000, 16'h0001, 1'b0, 1'b1, {16'h7FFF, 1'b1, 1'b1});
        dir6 ("w6_wrap",   6'h3F,    6'h01,    1'b0, 1'b0, {6'h00, 1'b1, 1'b0});

        stall16();
        rand16(300);
        exhaust6();
        reset_mid16();
        dir16("post_rst",  16'h1234, 16'h1111, 1'b1, 1'b0, {16'h2346, 1'b0, 1'b0});

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

endmodule
`default_nettype wire
